// File: rtl/shifter_spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shifter_spi_master_pkg
// Purpose  : Isa slice shared by the shifter SPI master: register width,
//            shifter operation codes, the serial packet layout and the
//            master FSM encoding.
// Revision : 1.0  initial release
// ============================================================================
package shifter_spi_master_pkg;

  localparam int REGISTER_SIZE = 8;
  localparam int SHIFT_BITS    = $clog2(REGISTER_SIZE);

  // SHL/SHR rotate through the barrel: bits leaving one end re-enter the other.
  typedef enum logic [1:0] {
    SHL = 2'd0,
    SHR = 2'd1,
    SAR = 2'd2,
    NOP = 2'd3
  } Operation;

  // op_code occupies the LSBs, so it is the first field on the wire.
  typedef struct packed {
    logic [SHIFT_BITS-1:0]    shift_amount;
    logic [REGISTER_SIZE-1:0] op;
    Operation                 op_code;
  } ShifterPacket;

  localparam int SHIFTER_PACKET_BITS = $bits(ShifterPacket);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    TX       = 3'd2,
    WAIT_ACK = 3'd3,
    RX       = 3'd4,
    DONE     = 3'd5
  } master_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_if.sv
`default_nettype none
// ============================================================================
// Module   : Spi
// Purpose  : Shared SPI bus: active-low slave selects, mosi and miso.
// Revision : 1.0  initial release
// ============================================================================
interface Spi #(
  parameter int NSS_WIDTH = 1
);
  logic [NSS_WIDTH-1:0] nss;
  logic                 mosi;
  logic                 miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/shifter_spi_master_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter. Grant is combinational and one-hot; the
//            search starts at the pointer, which moves past the winner when
//            i_advance is strobed with a request present.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic          w_found;
  logic [N-1:0]  w_grant;
  int            w_idx;

  // Scan requests starting at the pointer, first hit wins.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_win          = PW'(w_idx);
      end
    end
  end

  // Pointer moves to the requester after the winner so it gets lowest priority.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
    end
  end

  assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/shifter_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : shifter_spi_master
// Purpose  : SPI master sharing the serial barrel-shifter slave among several
//            requesters. Round-robin grant, start bit + LSB-first packet out,
//            wait for the slave's send marker, LSB-first result in, one-cycle
//            response pulse to the owner.
//            Optional macro SHIFTER_MASTER_TIMEOUT_EN: abort WAIT_ACK after
//            TIMEOUT_CYCLES and report o_rsp_error with zero data.
// Revision : 1.0  initial release
// ============================================================================
module shifter_spi_master
  import shifter_spi_master_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int NSS_WIDTH      = 1,
  parameter int SHIFTER_NSS    = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic         [NUM_REQUESTERS-1:0]      i_req_valid,
  input  ShifterPacket [NUM_REQUESTERS-1:0]      i_req_packet,
  output logic         [NUM_REQUESTERS-1:0]      o_req_ready,
  output logic         [NUM_REQUESTERS-1:0]      o_rsp_valid,
  output logic         [REGISTER_SIZE-1:0]       o_rsp_data,
  output logic                                   o_rsp_error,
  output logic                                   o_busy,
  Spi.MasterSpi                                  spi
);

  localparam int P       = SHIFTER_PACKET_BITS;
  localparam int R       = REGISTER_SIZE;
  localparam int MAX_PR  = (P > R) ? P : R;
  localparam int CNT_MAX = (MAX_PR > TIMEOUT_CYCLES) ? MAX_PR : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [NSS_WIDTH-1:0] c_nss_idle   = '1;
  localparam logic [NSS_WIDTH-1:0] c_nss_active = ~(NSS_WIDTH'(1) << SHIFTER_NSS);

  master_state_t             r_state;
  logic [CW-1:0]             r_cnt;
  logic [P-1:0]              r_shift;
  logic [NUM_REQUESTERS-1:0] r_owner;
  logic [R-1:0]              r_result;
  logic [NSS_WIDTH-1:0]      r_nss;
  logic                      r_mosi;
  logic [NUM_REQUESTERS-1:0] r_rsp_valid;
  logic [R-1:0]              r_rsp_data;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
  logic                      r_rsp_error;
`endif

  logic [NUM_REQUESTERS-1:0] w_grant;
  logic                      w_idle;
  ShifterPacket              w_sel_pkt;
  logic [R-1:0]              w_result_next;

  assign w_idle        = (r_state == IDLE);
  assign w_result_next = {spi.miso, r_result[R-1:1]};

  rr_arbiter #(
    .N (NUM_REQUESTERS)
  ) u_arb (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req     (i_req_valid),
    .i_advance (w_idle),
    .o_grant   (w_grant)
  );

  // One-hot OR-mux of the winning requester's packet.
  always_comb begin
    w_sel_pkt = ShifterPacket'('0);
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (w_grant[i]) w_sel_pkt = i_req_packet[i];
    end
  end

  // Transaction sequencer; all bus and response outputs are registered here.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_owner     <= '0;
      r_result    <= '0;
      r_nss       <= c_nss_idle;
      r_mosi      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
      r_rsp_error <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
      r_rsp_error <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (|i_req_valid) begin
            r_shift <= w_sel_pkt;
            r_owner <= w_grant;
            r_nss   <= c_nss_active;
            r_mosi  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          r_mosi  <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_cnt   <= '0;
          r_state <= TX;
        end
        TX: begin
          if (r_cnt == CW'(P - 1)) begin
            r_mosi  <= 1'b0;
            r_cnt   <= '0;
            r_state <= WAIT_ACK;
          end else begin
            r_mosi  <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        WAIT_ACK: begin
          if (spi.miso == 1'b1) begin
            r_cnt   <= '0;
            r_state <= RX;
          end
`ifdef SHIFTER_MASTER_TIMEOUT_EN
          else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_nss       <= c_nss_idle;
            r_rsp_valid <= r_owner;
            r_rsp_error <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        RX: begin
          r_result <= w_result_next;
          if (r_cnt == CW'(R - 1)) begin
            r_nss       <= c_nss_idle;
            r_rsp_valid <= r_owner;
            r_rsp_data  <= w_result_next;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_nss   <= c_nss_idle;
          r_mosi  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = w_idle ? w_grant : '0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = ~w_idle;
  assign spi.nss     = r_nss;
  assign spi.mosi    = r_mosi;
`ifdef SHIFTER_MASTER_TIMEOUT_EN
  assign o_rsp_error = r_rsp_error;
`else
  assign o_rsp_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shifter_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_spi_master
// Purpose  : Directed bench for shifter_spi_master with a behavioural
//            barrel-shifter slave on nss[1].
// Revision : 1.0  initial release
// ============================================================================
module tb_shifter_spi_master;
  import shifter_spi_master_pkg::*;

  localparam int PB = 13;            // 3 shift + 8 operand + 2 opcode bits
  localparam int LATENCY = 25;       // grant -> rsp pulse: 13 + 4 + 8
  localparam int SPACING = 26;       // grant -> next grant: 13 + 5 + 8

  localparam ShifterPacket PKT_A = '{shift_amount: 3'd1, op: 8'h81, op_code: SHL};
  localparam ShifterPacket PKT_B = '{shift_amount: 3'd4, op: 8'hF0, op_code: SHR};
  localparam ShifterPacket PKT_C = '{shift_amount: 3'd0, op: 8'h5A, op_code: SHL};

  logic               clk;
  logic               rst_n;
  logic         [1:0] req_valid;
  ShifterPacket [1:0] req_packet;
  logic         [1:0] req_ready;
  logic         [1:0] rsp_valid;
  logic         [7:0] rsp_data;
  logic               rsp_error;
  logic               busy;

  Spi #(.NSS_WIDTH(2)) spi_bus ();

  shifter_spi_master #(
    .NUM_REQUESTERS (2),
    .NSS_WIDTH      (2),
    .SHIFTER_NSS    (1),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_packet (req_packet),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_rsp_error  (rsp_error),
    .o_busy       (busy),
    .spi          (spi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic nss_other_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (spi_bus.nss[0] !== 1'b1) nss_other_low <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural barrel-shifter slave ----------------
  function automatic logic [7:0] barrel(input logic [PB-1:0] p);
    logic [2:0] a;
    logic [7:0] d;
    a = p[12:10];
    d = p[9:2];
    case (p[1:0])
      2'd0:    barrel = (d << a) | (d >> (4'd8 - {1'b0, a}));
      2'd1:    barrel = (d >> a) | (d << (4'd8 - {1'b0, a}));
      2'd2:    barrel = 8'($signed(d) >>> a);
      default: barrel = d;
    endcase
  endfunction

  int            s_state;
  int            s_cnt;
  logic [PB-1:0] s_pkt;
  logic [7:0]    s_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state      <= 0;
      s_cnt        <= 0;
      s_pkt        <= '0;
      s_res        <= '0;
      spi_bus.miso <= 1'b0;
    end else begin
      case (s_state)
        0: if (spi_bus.nss[1] == 1'b0 && spi_bus.mosi == 1'b1) begin
             s_state <= 1;
             s_cnt   <= 0;
           end
        1: begin
             s_pkt[s_cnt] <= spi_bus.mosi;
             if (s_cnt == PB - 1) s_state <= 2;
             else s_cnt <= s_cnt + 1;
           end
        2: begin
             s_res        <= barrel(s_pkt);
             spi_bus.miso <= 1'b1;
             s_state      <= 3;
           end
        3: begin
             spi_bus.miso <= s_res[0];
             s_cnt        <= 1;
             s_state      <= 4;
           end
        default: begin
             if (s_cnt == 8) begin
               spi_bus.miso <= 1'b0;
               s_state      <= 0;
             end else begin
               spi_bus.miso <= s_res[s_cnt];
               s_cnt        <= s_cnt + 1;
             end
           end
      endcase
    end
  end

  // ---------------- single transaction with full checking ----------------
  task automatic run_txn(input int idx, input ShifterPacket pkt, input logic [7:0] exp);
    logic [PB-1:0] bits;
    logic [1:0]    onehot;
    int            n;
    bits   = pkt;
    onehot = 2'b01 << idx;
    @(negedge clk);
    req_packet[idx] = pkt;
    req_valid[idx]  = 1'b1;
    #1;
    check($sformatf("ready%0d", idx), 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid[idx] = 1'b0;
    check("start_nss", 32'(spi_bus.nss), 32'(2'b01));
    check("start_mosi", 32'(spi_bus.mosi), 32'd1);
    check("busy", 32'(busy), 32'd1);
    for (int i = 0; i < PB; i++) begin
      @(negedge clk);
      check($sformatf("mosi_bit%0d", i), 32'(spi_bus.mosi), 32'(bits[i]));
    end
    n = PB + 1;
    while (rsp_valid == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", 32'(n), 32'(LATENCY));
    check("rsp_owner", 32'(rsp_valid), 32'(onehot));
    check("rsp_data", 32'(rsp_data), 32'(exp));
    check("rsp_error", 32'(rsp_error), 32'd0);
    check("done_nss", 32'(spi_bus.nss), 32'(2'b11));
  endtask

  initial begin
    int waited;
    int grant_cyc;
    int last_grant;
    int pulses;
    logic [1:0] exp_oh;

    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_packet = '0;
    last_grant = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_nss", 32'(spi_bus.nss), 32'(2'b11));
    check("rst_mosi", 32'(spi_bus.mosi), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(0, PKT_A, 8'h03);
    run_txn(1, PKT_B, 8'h0F);

    // Both requesters hold valid: grants must alternate 0,1,0,1.
    @(negedge clk);
    req_packet[0] = PKT_A;
    req_packet[1] = PKT_B;
    req_valid     = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      waited = 0;
      while (req_ready == 2'b00 && waited < 100) begin
        @(negedge clk);
        #1;
        waited++;
      end
      grant_cyc = cyc;
      check($sformatf("alt_grant%0d", k), 32'(req_ready), 32'(exp_oh));
      if (k > 0) check($sformatf("alt_spacing%0d", k), 32'(grant_cyc - last_grant), 32'(SPACING));
      last_grant = grant_cyc;
      waited = 0;
      @(negedge clk);
      while (rsp_valid == 2'b00 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("alt_owner%0d", k), 32'(rsp_valid), 32'(exp_oh));
      check($sformatf("alt_data%0d", k), 32'(rsp_data), (k % 2 == 0) ? 32'h03 : 32'h0F);
      if (k == 3) req_valid = 2'b00;
      #1;
    end

    // Reset in the middle of TX aborts without a response.
    @(negedge clk);
    req_packet[0] = PKT_A;
    req_valid[0]  = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_nss", 32'(spi_bus.nss), 32'(2'b11));
    check("abort_mosi", 32'(spi_bus.mosi), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) pulses++;
    end
    check("abort_no_rsp", 32'(pulses), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    run_txn(1, PKT_C, 8'h5A);
    @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    check("nss_other_high", 32'(nss_other_low), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
